spi_sender_ctrl: RTL and testbench

- Parametrised serial sender. It is the next generation of the existing 8-bit shift-out sender.
- Takes a WIDTH-bit word through a LOAD/READY handshake into a one-entry holding buffer.
- Generates its own SCLK and an active-low slave select, and shifts the word out on MOSI, MSB- or LSB-first.
- Sits between the parallel host datapath and the off-chip SPI pins. It reports frame completion with DONE and BUSY.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sender_ctrl_if.sv | 30 +++
 rtl/spi_sclk_div.sv | 41 ++++
 rtl/spi_sender_ctrl.sv | 125 ++++++++++++
 tb/tb_spi_sender_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sender slice.
//   state_t   : FSM state encoding (ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL)
//   DEF_WIDTH : default bits per frame
//   DEF_DIV   : default CLK cycles per SCLK half-period
//   cnt_w()   : width of the BIT_CNT port for a given frame width
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 2;

    // BIT_CNT must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_sender_ctrl_if.sv
// Host/pin bundle of the SPI sender.
//   master : host side, drives DATA/LOAD/TE, observes status and pins
//   slave  : sender side, takes DATA/LOAD/TE, drives READY, SCLK, MOSI,
//            SS_N, BUSY, DONE and BIT_CNT
interface spi_sender_ctrl_if
    import spi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0]          DATA;
    logic                      LOAD;
    logic                      TE;
    logic                      READY;
    logic                      SCLK;
    logic                      MOSI;
    logic                      SS_N;
    logic                      BUSY;
    logic                      DONE;
    logic [cnt_w(WIDTH)-1:0]   BIT_CNT;

    modport master (
        output DATA, LOAD, TE,
        input  READY, SCLK, MOSI, SS_N, BUSY, DONE, BIT_CNT
    );

    modport slave (
        input  DATA, LOAD, TE,
        output READY, SCLK, MOSI, SS_N, BUSY, DONE, BIT_CNT
    );
endinterface

// File: rtl/spi_sclk_div.sv
// SCLK divider for the SPI sender.
//   clk, rst_n : system clock, async active-low reset
//   run        : frame in progress; when low the counter sits at 0
//   te         : transfer enable; when low counter and SCLK freeze
//   toggle     : SCLK may toggle on half ticks (shift phase only)
//   half_tick  : single-cycle pulse on the last cycle of each half-period
//   sclk       : registered serial clock, idles at CPOL
module spi_sclk_div #(
    parameter int DIV  = 2,
    parameter int CPOL = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic te,
    input  logic toggle,
    output logic half_tick,
    output logic sclk
);
    localparam int   CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic IDLE_LVL = (CPOL != 0);

    logic [CW-1:0] cnt;

    assign half_tick = run && te && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= IDLE_LVL;
        end else if (!run) begin
            cnt  <= '0;
            sclk <= IDLE_LVL;
        end else if (te) begin
            cnt <= half_tick ? '0 : cnt + 1'b1;
            if (half_tick && toggle)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_sender_ctrl.sv
// Parametrised SPI shift-out sender.
//   CLK, CLR_N : system clock, async active-low reset
//   bus        : slave modport; host takes words via LOAD/READY into a
//                one-entry hold buffer, the sender frames each word with
//                SS_N low, generates SCLK and shifts it out on MOSI.
//                DONE pulses for one cycle at end of frame, BUSY is high
//                outside IDLE, BIT_CNT counts completed bits.
module spi_sender_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV       = DEF_DIV,
    parameter int MSB_FIRST = 1,
    parameter int CPOL      = 0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    spi_sender_ctrl_if.slave bus
);
    localparam int   BW       = cnt_w(WIDTH);
    localparam logic IDLE_LVL = (CPOL != 0);
    localparam logic MSB      = (MSB_FIRST != 0);

    state_t           state;
    logic             hold_valid;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic             mosi;
    logic             ss_n;
    logic             done;
    logic             half_tick;
    logic             sclk;
    logic             run;
    logic             toggle;
    logic             trail_edge;

    assign run    = (state != ST_IDLE);
    assign toggle = (state == ST_SHIFT);

    spi_sclk_div #(
        .DIV  (DIV),
        .CPOL (CPOL)
    ) u_div (
        .clk       (CLK),
        .rst_n     (CLR_N),
        .run       (run),
        .te        (bus.TE),
        .toggle    (toggle),
        .half_tick (half_tick),
        .sclk      (sclk)
    );

    // A half tick while SCLK is away from idle returns it to idle: that is
    // the trailing edge, where the next bit is presented.
    assign trail_edge = toggle && half_tick && (sclk != IDLE_LVL);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
            hold       <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            mosi       <= 1'b0;
            ss_n       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Hold accepts only when empty; the start below only fires when
            // full, so the two hold_valid updates never coincide.
            if (bus.LOAD && !hold_valid) begin
                hold       <= bus.DATA;
                hold_valid <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (hold_valid && bus.TE) begin
                        sreg       <= hold;
                        hold_valid <= 1'b0;
                        ss_n       <= 1'b0;
                        mosi       <= MSB ? hold[WIDTH-1] : hold[0];
                        state      <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (half_tick)
                        state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (trail_edge) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            // Last bit: MOSI keeps it until the next frame.
                            state <= ST_TRAIL;
                        end else begin
                            sreg <= MSB ? (sreg << 1) : (sreg >> 1);
                            mosi <= MSB ? sreg[WIDTH-2] : sreg[1];
                        end
                    end
                end
                ST_TRAIL: begin
                    if (half_tick) begin
                        state   <= ST_IDLE;
                        ss_n    <= 1'b1;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.READY   = ~hold_valid;
    assign bus.BUSY    = run;
    assign bus.SCLK    = sclk;
    assign bus.MOSI    = mosi;
    assign bus.SS_N    = ss_n;
    assign bus.DONE    = done;
    assign bus.BIT_CNT = bit_cnt;

endmodule

// File: tb/tb_spi_sender_ctrl.sv
// Bench for spi_sender_ctrl: default instance (8 bit, DIV 2, MSB first,
// CPOL 0) and a 12 bit, DIV 1, LSB first, CPOL 1 instance. Monitors record
// the bits seen at each leading SCLK edge and the frame timing; the tests
// compare those against a bit-order/frame-length model.
module tb_spi_sender_ctrl;
    import spi_pkg::*;

    logic CLK   = 1'b0;
    logic CLR_N = 1'b0;
    always #5 CLK = ~CLK;

    spi_sender_ctrl_if #(.WIDTH(8))  ia ();
    spi_sender_ctrl_if #(.WIDTH(12)) ib ();

    spi_sender_ctrl #(.WIDTH(8), .DIV(2), .MSB_FIRST(1), .CPOL(0)) dut_a (
        .CLK(CLK), .CLR_N(CLR_N), .bus(ia.slave));
    spi_sender_ctrl #(.WIDTH(12), .DIV(1), .MSB_FIRST(0), .CPOL(1)) dut_b (
        .CLK(CLK), .CLR_N(CLR_N), .bus(ib.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: bit i of the result is the i-th bit on the wire.
    function automatic logic [15:0] exp_seq(input logic [15:0] d, input int w, input bit msb);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < w; i++) s[i] = msb ? d[w-1-i] : d[i];
        return s;
    endfunction

    function automatic int exp_len(input int w, input int div, input int pause);
        return div * (2 * w + 2) + pause;
    endfunction

    // ---------------- monitors ----------------
    logic [15:0] a_cur, b_cur;
    int a_n, b_n, a_start, b_start, a_last_done;
    bit a_in, b_in, a_had_done;
    logic a_pss = 1'b1, a_psclk = 1'b0, b_pss = 1'b1, b_psclk = 1'b1;
    logic [15:0] a_words[$], b_words[$];
    int a_lens[$], b_lens[$], a_nb[$], b_nb[$], a_gaps[$];

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (!CLR_N) begin
            a_in = 0; a_had_done = 0; a_n = 0;
            b_in = 0; b_n = 0;
        end else begin
            if (a_pss && !ia.SS_N) begin
                if (a_had_done) a_gaps.push_back(cyc - a_last_done);
                a_in = 1; a_start = cyc; a_cur = '0; a_n = 0;
            end
            if (a_in && !a_psclk && ia.SCLK) begin
                if (a_n < 16) a_cur[a_n] = ia.MOSI;
                a_n++;
            end
            if (ia.DONE) begin
                a_words.push_back(a_cur); a_lens.push_back(cyc - a_start);
                a_nb.push_back(a_n); a_in = 0; a_had_done = 1; a_last_done = cyc;
            end
            if (b_pss && !ib.SS_N) begin
                b_in = 1; b_start = cyc; b_cur = '0; b_n = 0;
            end
            if (b_in && b_psclk && !ib.SCLK) begin
                if (b_n < 16) b_cur[b_n] = ib.MOSI;
                b_n++;
            end
            if (ib.DONE) begin
                b_words.push_back(b_cur); b_lens.push_back(cyc - b_start);
                b_nb.push_back(b_n); b_in = 0;
            end
        end
        a_pss = ia.SS_N; a_psclk = ia.SCLK;
        b_pss = ib.SS_N; b_psclk = ib.SCLK;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clr_a();
        a_words.delete(); a_lens.delete(); a_nb.delete(); a_gaps.delete();
        a_had_done = 0;
    endtask

    task automatic load_a(input logic [7:0] d);
        ia.DATA = d; ia.LOAD = 1'b1;
        tick(1);
        ia.LOAD = 1'b0;
    endtask

    task automatic load_b(input logic [11:0] d);
        ib.DATA = d; ib.LOAD = 1'b1;
        tick(1);
        ib.LOAD = 1'b0;
    endtask

    task automatic wait_words_a(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (a_words.size() >= n) ok = 1;
            else tick(1);
        end
        if (a_words.size() >= n) ok = 1;
    endtask

    task automatic wait_bitcnt_a(input int v, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (int'(ia.BIT_CNT) == v) ok = 1;
            else tick(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] ea, ga;
        logic [9:0] eb, gb;
        CLR_N = 1'b0;
        tick(3);
        ea = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        eb = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        ga = {ia.READY, ia.SS_N, ia.SCLK, ia.MOSI, ia.BUSY, ia.DONE, ia.BIT_CNT};
        checks++;
        if (ga !== ea) begin
            errors++; $display("FAIL reset_hold_a got %b want %b", ga, ea);
        end
        CLR_N = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            ga = {ia.READY, ia.SS_N, ia.SCLK, ia.MOSI, ia.BUSY, ia.DONE, ia.BIT_CNT};
            gb = {ib.READY, ib.SS_N, ib.SCLK, ib.MOSI, ib.BUSY, ib.DONE, ib.BIT_CNT};
            checks++;
            if (ga !== ea) begin
                errors++; $display("FAIL reset_idle_a cycle %0d got %b want %b", i, ga, ea);
            end
            checks++;
            if (gb !== eb) begin
                errors++; $display("FAIL reset_idle_b cycle %0d got %b want %b", i, gb, eb);
            end
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        logic [15:0] e;
        clr_a();
        load_a(8'hA5);
        checks++;
        if ({ia.READY, ia.SS_N} !== 2'b01) begin
            errors++; $display("FAIL single_after_load got %b want 01", {ia.READY, ia.SS_N});
        end
        tick(1);
        checks++;
        if ({ia.SS_N, ia.BUSY, ia.MOSI, ia.READY} !== 4'b0111) begin
            errors++; $display("FAIL single_ss_low got %b want 0111",
                               {ia.SS_N, ia.BUSY, ia.MOSI, ia.READY});
        end
        wait_words_a(1, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout got 0 frames want 1");
        end else begin
            e = exp_seq(16'h00A5, 8, 1'b1);
            checks++;
            if (a_words[0] !== e || a_nb[0] != 8) begin
                errors++; $display("FAIL single_bits got %h/%0d want %h/8", a_words[0], a_nb[0], e);
            end
            checks++;
            if (a_lens[0] != exp_len(8, 2, 0)) begin
                errors++; $display("FAIL single_len got %0d want %0d", a_lens[0], exp_len(8, 2, 0));
            end
            checks++;
            if ({ia.DONE, ia.SS_N, ia.BIT_CNT} !== 6'b110000) begin
                errors++; $display("FAIL single_done_edge got %b want 110000",
                                   {ia.DONE, ia.SS_N, ia.BIT_CNT});
            end
            tick(1);
            checks++;
            if ({ia.DONE, ia.BUSY, ia.SCLK} !== 3'b000) begin
                errors++; $display("FAIL single_done_pulse got %b want 000",
                                   {ia.DONE, ia.BUSY, ia.SCLK});
            end
        end
    endtask

    task automatic test_lsb_w12();
        logic [11:0] d;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 12'h801 : 12'($urandom);
            b_words.delete(); b_lens.delete(); b_nb.delete();
            checks++;
            if (ib.SCLK !== 1'b1) begin
                errors++; $display("FAIL lsb_sclk_idle got %b want 1", ib.SCLK);
            end
            load_b(d);
            ok = 0;
            for (int i = 0; i < 80 && !ok; i++) begin
                if (b_words.size() >= 1) ok = 1;
                else tick(1);
            end
            checks++;
            if (!ok) begin
                errors++; $display("FAIL lsb_timeout word %h got 0 frames want 1", d);
            end else begin
                checks++;
                if (b_words[0] !== exp_seq({4'd0, d}, 12, 1'b0) || b_nb[0] != 12) begin
                    errors++; $display("FAIL lsb_bits word %h got %h/%0d want %h/12", d,
                                       b_words[0], b_nb[0], exp_seq({4'd0, d}, 12, 1'b0));
                end
                checks++;
                if (b_lens[0] != exp_len(12, 1, 0)) begin
                    errors++; $display("FAIL lsb_len got %0d want %0d", b_lens[0], exp_len(12, 1, 0));
                end
            end
            tick(2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] third;
        bit ok;
        clr_a();
        third = 8'($urandom);
        if (third == 8'hC3) third = 8'h5A;
        load_a(8'h3C);
        tick(1);
        load_a(8'hC3);
        checks++;
        if (ia.READY !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_full got %b want 0", ia.READY);
        end
        ia.DATA = third; ia.LOAD = 1'b1;
        tick(1);
        ia.LOAD = 1'b0;
        wait_words_a(2, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout got %0d frames want 2", a_words.size());
        end else begin
            checks++;
            if (a_words[0] !== exp_seq(16'h003C, 8, 1'b1)) begin
                errors++; $display("FAIL b2b_first got %h want %h", a_words[0], exp_seq(16'h003C, 8, 1'b1));
            end
            checks++;
            if (a_words[1] !== exp_seq(16'h00C3, 8, 1'b1)) begin
                errors++; $display("FAIL b2b_second got %h want %h", a_words[1], exp_seq(16'h00C3, 8, 1'b1));
            end
            checks++;
            if (a_gaps.size() != 1 || a_gaps[0] != 1) begin
                errors++; $display("FAIL b2b_gap got %0d gaps first %0d want 1 gap of 1",
                                   a_gaps.size(), (a_gaps.size() > 0) ? a_gaps[0] : -1);
            end
            tick(60);
            checks++;
            if (a_words.size() != 2 || ia.READY !== 1'b1 || ia.SS_N !== 1'b1) begin
                errors++; $display("FAIL b2b_third_dropped got %0d frames ready %b want 2 frames ready 1",
                                   a_words.size(), ia.READY);
            end
        end
    endtask

    task automatic test_te_pause();
        logic [7:0] d, d2;
        logic [15:0] s;
        logic [6:0] e, g;
        bit ok;
        clr_a();
        d  = 8'($urandom);
        d2 = 8'($urandom);
        s  = exp_seq({8'd0, d}, 8, 1'b1);
        load_a(d);
        wait_bitcnt_a(3, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL pause_timeout got bit_cnt %0d want 3", ia.BIT_CNT);
        end else begin
            ia.TE = 1'b0;
            e = {1'b0, s[3], 4'd3, 1'b0};
            for (int i = 0; i < 10; i++) begin
                if (i == 0) begin ia.DATA = d2; ia.LOAD = 1'b1; end
                else ia.LOAD = 1'b0;
                tick(1);
                g = {ia.SCLK, ia.MOSI, ia.BIT_CNT, ia.SS_N};
                checks++;
                if (g !== e) begin
                    errors++; $display("FAIL pause_frozen cycle %0d got %b want %b", i, g, e);
                end
            end
            checks++;
            if (ia.READY !== 1'b0) begin
                errors++; $display("FAIL pause_hold_load got %b want 0", ia.READY);
            end
            ia.TE = 1'b1;
            wait_words_a(2, 200, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL pause_done_timeout got %0d frames want 2", a_words.size());
            end else begin
                checks++;
                if (a_words[0] !== s || a_lens[0] != exp_len(8, 2, 10)) begin
                    errors++; $display("FAIL pause_frame got %h len %0d want %h len %0d",
                                       a_words[0], a_lens[0], s, exp_len(8, 2, 10));
                end
                checks++;
                if (a_words[1] !== exp_seq({8'd0, d2}, 8, 1'b1) || a_lens[1] != exp_len(8, 2, 0)) begin
                    errors++; $display("FAIL pause_next got %h len %0d want %h len %0d",
                                       a_words[1], a_lens[1], exp_seq({8'd0, d2}, 8, 1'b1), exp_len(8, 2, 0));
                end
            end
        end
        tick(2);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d3;
        logic [9:0] g;
        bit ok;
        clr_a();
        load_a(8'($urandom));
        tick(1);
        load_a(8'($urandom));
        wait_bitcnt_a(5, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_timeout got bit_cnt %0d want 5", ia.BIT_CNT);
        end else begin
            CLR_N = 1'b0;
            #1;
            g = {ia.SS_N, ia.SCLK, ia.BIT_CNT, ia.READY, ia.BUSY, ia.DONE, ia.MOSI};
            checks++;
            if (g !== 10'b1000001000) begin
                errors++; $display("FAIL rstmid_outputs got %b want 1000001000", g);
            end
            tick(2);
            CLR_N = 1'b1;
            tick(50);
            checks++;
            if (a_words.size() != 0 || ia.BUSY !== 1'b0 || ia.READY !== 1'b1) begin
                errors++; $display("FAIL rstmid_discard got %0d frames busy %b ready %b want 0 0 1",
                                   a_words.size(), ia.BUSY, ia.READY);
            end
            d3 = 8'($urandom);
            load_a(d3);
            wait_words_a(1, 100, ok);
            checks++;
            if (!ok || a_words[0] !== exp_seq({8'd0, d3}, 8, 1'b1) || a_lens[0] != exp_len(8, 2, 0)) begin
                errors++; $display("FAIL rstmid_clean_frame got %0d frames want frame %h len %0d",
                                   a_words.size(), exp_seq({8'd0, d3}, 8, 1'b1), exp_len(8, 2, 0));
            end
        end
        tick(2);
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] d;
        int k, budget;
        clr_a();
        k = 0;
        budget = 4000;
        while ((k < 6 || a_words.size() < 6) && budget > 0) begin
            ia.TE = ($urandom_range(0, 3) != 0);
            if (k < 6 && ia.READY === 1'b1 && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                ia.DATA = d; ia.LOAD = 1'b1;
                sent.push_back(d);
                k++;
            end else begin
                ia.LOAD = 1'b0;
            end
            tick(1);
            budget--;
            checks++;
            if (int'(ia.BIT_CNT) > 8) begin
                errors++; $display("FAIL rand_bitcnt_range got %0d want <=8", ia.BIT_CNT);
            end
        end
        ia.LOAD = 1'b0;
        ia.TE   = 1'b1;
        checks++;
        if (a_words.size() != 6) begin
            errors++; $display("FAIL rand_count got %0d want 6", a_words.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (a_words[i] !== exp_seq({8'd0, sent[i]}, 8, 1'b1) || a_nb[i] != 8) begin
                    errors++; $display("FAIL rand_word %0d got %h/%0d want %h/8", i,
                                       a_words[i], a_nb[i], exp_seq({8'd0, sent[i]}, 8, 1'b1));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.DATA = '0; ia.LOAD = 1'b0; ia.TE = 1'b1;
        ib.DATA = '0; ib.LOAD = 1'b0; ib.TE = 1'b1;
        test_reset();
        test_single_frame();
        test_lsb_w12();
        test_back_to_back();
        test_te_pause();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
